// File: rtl/knight_move_sequencer.sv
// rtl/knight_move_sequencer.sv - knight move sweep: board reads, legality check, move stream
// Piece encoding {type[2:0], col[2:0], row[2:0], color}; type 0 = empty, 2 = knight; color 1 = black.

module move_checker_knight (
  input  logic [9:0]  src_piece,
  input  logic [9:0]  dest_piece,
  input  logic [5:0]  dest_sq,
  output logic        valid,
  output logic [15:0] formatted_move
);
  localparam logic [2:0] KNIGHT = 3'd2;
  localparam logic [2:0] EMPTY  = 3'd0;

  logic [2:0] s_col, s_row, d_col, d_row, adc, adr;
  logic       geom, empty, enemy;
  logic [5:0] unused_dest_coords;

  assign s_col = src_piece[6:4];
  assign s_row = src_piece[3:1];
  assign d_col = dest_sq[5:3];
  assign d_row = dest_sq[2:0];
  assign adc   = (s_col > d_col) ? s_col - d_col : d_col - s_col;
  assign adr   = (s_row > d_row) ? s_row - d_row : d_row - s_row;
  assign geom  = ((adc == 3'd1) && (adr == 3'd2)) || ((adc == 3'd2) && (adr == 3'd1));
  assign empty = (dest_piece[9:7] == EMPTY);
  assign enemy = (dest_piece[0] != src_piece[0]);
  // Square coordinates come from the read address, not from the stored piece.
  assign unused_dest_coords = dest_piece[6:1];

  assign valid          = (src_piece[9:7] == KNIGHT) && geom && (empty || enemy);
  assign formatted_move = {2'b00, 1'b0, !empty, s_col, s_row, dest_sq};
endmodule

module knight_move_sequencer #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [9:0]  src_piece,
  output logic        rd_en,
  output logic [5:0]  rd_addr,
  input  logic [9:0]  rd_data,
  output logic        move_valid,
  input  logic        move_ready,
  output logic [15:0] move_data,
  output logic        busy,
  output logic        done,
  output logic [3:0]  move_count
);
  localparam logic [2:0] KNIGHT = 3'd2;

  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("knight_move_sequencer supports RD_LAT == 1 only");
  end

  typedef enum logic [2:0] {S_IDLE, S_OFFSET, S_CHECK, S_EMIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [9:0]  piece_q, piece_d;
  logic [5:0]  dest_q, dest_d;
  logic [15:0] move_data_q, move_data_d;
  logic [3:0]  move_count_q, move_count_d;

  logic [3:0]  off_c, off_r, dcol, drow;
  logic        on_board, adv;
  logic        chk_valid;
  logic [15:0] chk_move;

  move_checker_knight u_checker (
    .src_piece      (piece_q),
    .dest_piece     (rd_data),
    .dest_sq        (dest_q),
    .valid          (chk_valid),
    .formatted_move (chk_move)
  );

  always_comb begin
    off_c = 4'h0;
    off_r = 4'h0;
    case (idx_q)
      3'd0: begin off_c = 4'hF; off_r = 4'h2; end
      3'd1: begin off_c = 4'h1; off_r = 4'h2; end
      3'd2: begin off_c = 4'h2; off_r = 4'h1; end
      3'd3: begin off_c = 4'h2; off_r = 4'hF; end
      3'd4: begin off_c = 4'h1; off_r = 4'hE; end
      3'd5: begin off_c = 4'hF; off_r = 4'hE; end
      3'd6: begin off_c = 4'hE; off_r = 4'hF; end
      default: begin off_c = 4'hE; off_r = 4'h1; end
    endcase
  end

  // 4-bit wrap: negatives and 8/9 both land with bit 3 set.
  assign dcol     = {1'b0, piece_q[6:4]} + off_c;
  assign drow     = {1'b0, piece_q[3:1]} + off_r;
  assign on_board = !dcol[3] && !drow[3];

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    piece_d      = piece_q;
    dest_d       = dest_q;
    move_data_d  = move_data_q;
    move_count_d = move_count_q;
    rd_en        = 1'b0;
    rd_addr      = 6'd0;
    adv          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          piece_d      = src_piece;
          idx_d        = 3'd0;
          move_count_d = 4'd0;
          state_d      = S_OFFSET;
        end
      end
      S_OFFSET: begin
        // The type test uses the latched piece, so it takes the first sweep cycle.
        if (piece_q[9:7] != KNIGHT) begin
          state_d = S_DONE;
        end else if (on_board) begin
          rd_en   = 1'b1;
          rd_addr = {dcol[2:0], drow[2:0]};
          dest_d  = {dcol[2:0], drow[2:0]};
          state_d = S_CHECK;
        end else begin
          adv = 1'b1;
        end
      end
      S_CHECK: begin
        if (chk_valid) begin
          move_data_d  = chk_move;
          move_count_d = move_count_q + 4'd1;
          state_d      = S_EMIT;
        end else begin
          adv = 1'b1;
        end
      end
      S_EMIT: begin
        if (move_ready) adv = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (idx_q == 3'd7) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + 3'd1;
        state_d = S_OFFSET;
      end
    end

    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      move_count_d = move_count_q;
      rd_en        = 1'b0;
      rd_addr      = 6'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      piece_q      <= 10'd0;
      dest_q       <= 6'd0;
      move_data_q  <= 16'd0;
      move_count_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      piece_q      <= piece_d;
      dest_q       <= dest_d;
      move_data_q  <= move_data_d;
      move_count_q <= move_count_d;
    end
  end

  assign move_valid = (state_q == S_EMIT);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign move_data  = move_data_q;
  assign move_count = move_count_q;
endmodule

// File: tb/tb_knight_move_sequencer.sv
// tb/tb_knight_move_sequencer.sv - table vectors, random sweeps vs move-list model, abort/reset cases

module tb_knight_move_sequencer;
  localparam logic [2:0] T_EMPTY  = 3'd0;
  localparam logic [2:0] T_PAWN   = 3'd1;
  localparam logic [2:0] T_KNIGHT = 3'd2;
  localparam logic [2:0] T_BISHOP = 3'd3;
  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, move_ready;
  logic [9:0]  src_piece, rd_data;
  logic        rd_en, move_valid, busy, done;
  logic [5:0]  rd_addr;
  logic [15:0] move_data;
  logic [3:0]  move_count;

  logic [9:0]  board [64];
  logic [5:0]  mem_addr;
  int          checks = 0;
  int          failures = 0;
  int          oc [8] = '{-1, 1, 2, 2, 1, -1, -2, -2};
  int          orw[8] = '{ 2, 2, 1, -1, -2, -2, -1, 1};

  knight_move_sequencer #(.RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .src_piece(src_piece),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .move_valid(move_valid),
    .move_ready(move_ready), .move_data(move_data), .busy(busy), .done(done),
    .move_count(move_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      mem_addr = rd_addr;
      #1 rd_data = board[mem_addr];
    end
  end

  function automatic logic [9:0] mk(logic [2:0] t, int c, int r, logic color);
    return {t, 3'(c), 3'(r), color};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic setup_board(int id);
    for (int i = 0; i < 64; i++) board[i] = 10'd0;
    if (id == 1) board[1*8+2] = mk(T_PAWN, 1, 2, BLACK);
    for (int k = 0; k < 8; k++) begin
      if (id == 2) board[(3+oc[k])*8 + 3+orw[k]] = mk(T_PAWN, 3+oc[k], 3+orw[k], BLACK);
      if (id == 3) board[(3+oc[k])*8 + 3+orw[k]] = mk(T_PAWN, 3+oc[k], 3+orw[k], WHITE);
    end
  endtask

  task automatic random_board();
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 2) == 0) board[i] = 10'd0;
      else board[i] = mk(3'($urandom_range(1, 6)), i / 8, i % 8, 1'($urandom_range(0, 1)));
    end
  endtask

  // abort_k > 0: interrupt at the first cycle of the abort_k-th emitted move (abort, or reset if use_rst).
  task automatic run_sweep(input logic [9:0] src, input int stall_first, input int stall_max,
                           input int abort_k, input bit use_rst,
                           output logic [15:0] first_data, output int got_count, output int done_cyc);
    logic [15:0] exp_moves[$];
    int          stalls[$];
    int          cost, exp_reads, reads, cyc, mi, stall_left;
    int          sc, sr, c, r;
    logic [9:0]  p;
    bit          interrupted;

    sc = int'(src[6:4]);
    sr = int'(src[3:1]);
    cost = 0;
    exp_reads = 0;
    if (src[9:7] != T_KNIGHT) begin
      cost = 1;
    end else begin
      for (int k = 0; k < 8; k++) begin
        c = sc + oc[k];
        r = sr + orw[k];
        if (c < 0 || c > 7 || r < 0 || r > 7) begin
          cost += 1;
        end else begin
          exp_reads++;
          p = board[c*8 + r];
          if (p[9:7] == T_EMPTY || p[0] != src[0]) begin
            exp_moves.push_back({2'b00, 1'b0, p[9:7] != T_EMPTY, 3'(sc), 3'(sr), 3'(c), 3'(r)});
            stalls.push_back(exp_moves.size() == 1 ? stall_first : $urandom_range(0, stall_max));
            cost += 3 + stalls[stalls.size()-1];
          end else begin
            cost += 2;
          end
        end
      end
    end

    first_data = 16'd0;
    done_cyc = -1;
    reads = 0;
    mi = 0;
    interrupted = 0;
    stall_left = (stalls.size() > 0) ? stalls[0] : 0;
    start = 1'b1;
    src_piece = src;
    @(posedge clk); #1;
    start = 1'b0;
    src_piece = 10'($urandom);
    cyc = 1;
    while (cyc < 300) begin
      if (rd_en) reads++;
      chk("busy_in_sweep", busy, 1);
      if (move_valid) begin
        chk("move_index", mi < exp_moves.size(), 1);
        if (mi < exp_moves.size()) chk("move_data", move_data, exp_moves[mi]);
        if (mi == 0) first_data = move_data;
        if (abort_k > 0 && mi == abort_k - 1) begin
          interrupted = 1;
          move_ready = 1'b0;
          if (use_rst) begin
            #1 rst_n = 1'b0;
            #1;
            chk("rst_rd_en", rd_en, 0);
            chk("rst_rd_addr", rd_addr, 0);
            chk("rst_move_valid", move_valid, 0);
            chk("rst_move_data", move_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_move_count", move_count, 0);
            @(negedge clk) rst_n = 1'b1;
            @(posedge clk); #1;
          end else begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_move_valid", move_valid, 0);
            chk("abort_rd_en", rd_en, 0);
            chk("abort_count", move_count, abort_k);
            for (int i = 0; i < 3; i++) begin
              chk("abort_no_done", done, 0);
              @(posedge clk); #1;
            end
          end
          break;
        end
        if (stall_left > 0) begin
          move_ready = 1'b0;
          stall_left--;
        end else begin
          move_ready = 1'b1;
          mi++;
          stall_left = (mi < stalls.size()) ? stalls[mi] : 0;
        end
      end else begin
        move_ready = 1'($urandom_range(0, 1));
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    move_ready = 1'b0;
    got_count = int'(move_count);
    if (!interrupted) begin
      chk("done_cycle", done_cyc, cost + 1);
      chk("move_count", move_count, exp_moves.size());
      chk("moves_emitted", mi, exp_moves.size());
      chk("reads", reads, exp_reads);
      @(posedge clk); #1;
      chk("done_single", done, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  typedef struct {
    logic [9:0]  src;
    int          board_id;
    int          stall_first;
    logic [15:0] exp_first;
    int          exp_count;
    int          exp_done;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] fd;
  int          cnt, dc;

  initial begin
    vecs[0] = '{mk(T_KNIGHT, 0, 0, WHITE), 0, 0, 16'h000A, 2, 13};
    vecs[1] = '{mk(T_KNIGHT, 0, 0, WHITE), 1, 0, 16'h100A, 2, 13};
    vecs[2] = '{mk(T_KNIGHT, 3, 3, WHITE), 2, 0, 16'h16D5, 8, 25};
    vecs[3] = '{mk(T_KNIGHT, 3, 3, WHITE), 3, 0, 16'h0000, 0, 17};
    vecs[4] = '{mk(T_KNIGHT, 0, 0, WHITE), 0, 5, 16'h000A, 2, 18};
    vecs[5] = '{mk(T_BISHOP, 3, 3, WHITE), 0, 0, 16'h0000, 0, 2};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; move_ready = 1'b0;
    src_piece = 10'd0; rd_data = 10'd0;
    setup_board(0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_en", rd_en, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_move_valid", move_valid, 0);
    chk("reset_move_data", move_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_move_count", move_count, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      setup_board(vecs[v].board_id);
      run_sweep(vecs[v].src, vecs[v].stall_first, 0, 0, 0, fd, cnt, dc);
      chk($sformatf("vec%0d_first", v), fd, vecs[v].exp_first);
      chk($sformatf("vec%0d_count", v), cnt, vecs[v].exp_count);
      chk($sformatf("vec%0d_done", v), dc, vecs[v].exp_done);
    end

    for (int n = 0; n < 25; n++) begin
      random_board();
      run_sweep(mk(($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : T_KNIGHT,
                   $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1))),
                $urandom_range(0, 3), 3, 0, 0, fd, cnt, dc);
    end

    for (int m = 0; m < 2; m++) begin
      setup_board(2);
      run_sweep(vecs[2].src, 0, 0, 3, m == 1, fd, cnt, dc);
      run_sweep(vecs[2].src, 0, 0, 0, 0, fd, cnt, dc);
      chk("post_interrupt_count", cnt, 8);
      chk("post_interrupt_done", dc, 25);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
